// File: rtl/rr_arb_pkg.sv
// Shared types and helpers for the 4-way held round-robin grant block.
// Imported by the interface, the arbiter core and the top.
package rr_arb_pkg;

  localparam int N_REQ = 4;
  localparam int ID_W  = 2;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  function automatic logic [ID_W-1:0] onehot_to_id(
    input logic [N_REQ-1:0] oh
  );
    onehot_to_id = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (oh[i]) onehot_to_id = ID_W'(i);
    end
  endfunction

endpackage

// File: rtl/rr_grant_hold4_if.sv
// Request/grant bundle between requesters and the grant controller.
// master = requester side, slave = arbiter side.
interface rr_grant_hold4_if;
  import rr_arb_pkg::*;

  logic [N_REQ-1:0] REQ;
  logic             DONE;
  logic [N_REQ-1:0] GNT;
  logic [ID_W-1:0]  GNT_ID;
  logic             VALID;
  logic             TIMEOUT;

  modport master (
    output REQ, DONE,
    input  GNT, GNT_ID, VALID, TIMEOUT
  );

  modport slave (
    input  REQ, DONE,
    output GNT, GNT_ID, VALID, TIMEOUT
  );

endinterface

// File: rtl/lowest_first4.sv
// Isolates the lowest set bit of a 4-bit vector (I & ~(I-1)).
// Purely combinational.
module lowest_first4 (
  input  logic [3:0] I,
  output logic [3:0] O
);

  assign O = I & ~(I - 4'd1);

endmodule

// File: rtl/rr_grant_hold4.sv
// Registered round-robin grant controller for 4 requesters with grant
// hold, hold-limit watchdog and a forced idle gap between grants.
module rr_grant_hold4
  import rr_arb_pkg::*;
#(
  parameter int MAX_HOLD = 8,
  parameter int HOLD_W   = 4
) (
  input  logic          CLK,
  input  logic          RESETN,
  rr_grant_hold4_if.slave bus
);

  localparam bit LIM_EN = (MAX_HOLD != 0);
  localparam logic [HOLD_W-1:0] LIM =
    HOLD_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

  state_t            r_state;
  logic [N_REQ-1:0]  r_gnt;
  logic [ID_W-1:0]   r_id;
  logic [ID_W-1:0]   r_last;
  logic [HOLD_W-1:0] r_cnt;
  logic              r_to;

  logic [N_REQ:0]    w_mask;
  logic [N_REQ-1:0]  w_above;
  logic [N_REQ-1:0]  w_lo_above;
  logic [N_REQ-1:0]  w_lo_all;
  logic [N_REQ-1:0]  w_pick;
  logic [ID_W-1:0]   w_pick_id;
  logic              w_held;
  logic              w_lim;
  logic              w_rel;
  logic              w_sat;

  // mask is one bit wider so last=3 yields an empty "above" set
  assign w_mask  = (5'd2 << r_last) - 5'd1;
  assign w_above = bus.REQ & ~w_mask[N_REQ-1:0];

  lowest_first4 u_lo_above (
    .I (w_above),
    .O (w_lo_above)
  );

  lowest_first4 u_lo_all (
    .I (bus.REQ),
    .O (w_lo_all)
  );

  assign w_pick    = (|w_above) ? w_lo_above : w_lo_all;
  assign w_pick_id = onehot_to_id(w_pick);

  assign w_held = |(bus.REQ & r_gnt);
  assign w_lim  = LIM_EN && (r_cnt == LIM);
  assign w_rel  = bus.DONE | ~w_held | w_lim;
  assign w_sat  = &r_cnt;

  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      r_state <= IDLE;
      r_gnt   <= '0;
      r_id    <= '0;
      r_last  <= ID_W'(N_REQ - 1);
      r_cnt   <= '0;
      r_to    <= 1'b0;
    end else begin
      r_to <= 1'b0;
      case (r_state)
        IDLE: begin
          if (|bus.REQ) begin
            r_gnt   <= w_pick;
            r_id    <= w_pick_id;
            r_last  <= w_pick_id;
            r_cnt   <= '0;
            r_state <= HOLD;
          end
        end
        HOLD: begin
          if (w_rel) begin
            r_gnt   <= '0;
            r_id    <= '0;
            r_state <= IDLE;
            r_to    <= w_lim & ~bus.DONE & w_held;
          end else if (!w_sat) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_gnt   <= '0;
          r_id    <= '0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.GNT     = r_gnt;
  assign bus.GNT_ID  = r_id;
  assign bus.VALID   = |r_gnt;
  assign bus.TIMEOUT = r_to;

endmodule
